// File: rtl/timer_pkg.sv
// Register map and field positions for the rysy timer, shared with address decode.
// No logic; constants and types only.
// Not applicable: nothing here carries flow control.
package timer_pkg;

    // Word offsets of the four timer registers (addr[1:0])
    typedef enum logic [1:0] {
        TMR_CTRL  = 2'd0,
        TMR_COUNT = 2'd1,
        TMR_CMP   = 2'd2,
        TMR_STAT  = 2'd3
    } tmr_reg_e;

    // CTRL field positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_DIV_LSB = 8;

    // STATUS flag positions
    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by div+1 and emits a one-cycle tick while enabled.
// Latency: tick is combinational from the registered phase count; first tick div+1 cycles after enable.
// No backpressure: tick is a pulse, the consumer must take it in the cycle it fires.
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == div);

    // Phase counter: restarts on disable or on any CTRL write, wraps after reaching div
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (!en || clr) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/rysy_timer.sv
// Memory-mapped prescaled 32-bit timer with compare/auto-reload, sticky flags and level irq.
// Latency: read data registered one cycle after addr; writes take effect at the sampling edge.
// No backpressure: the slave always accepts a write and always returns read data next cycle.
module rysy_timer
    import timer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         addr,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               we,
    output logic [WIDTH-1:0]   q,
    output logic               irq
);

    localparam int NB = WIDTH / 8;

    // Replace only the byte lanes whose enable is set
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [NB-1:0]    lane_en
    );
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < NB; i++) begin
            if (lane_en[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    logic               ctrl_en;
    logic               ctrl_reload;
    logic               ctrl_irq_en;
    logic [PRESC_W-1:0] ctrl_div;
    logic [WIDTH-1:0]   count_r;
    logic [WIDTH-1:0]   cmp_r;
    logic               match_f;
    logic               ovf_f;

    tmr_reg_e         sel;
    logic             wr_ctrl;
    logic             wr_count;
    logic             wr_cmp;
    logic             wr_stat;
    logic [WIDTH-1:0] ctrl_img;
    logic [WIDTH-1:0] stat_img;
    logic [WIDTH-1:0] ctrl_new;
    logic             tick;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_nxt;
    logic             set_match;
    logic             set_ovf;
    logic             hw_stop;
    logic             clr_match;
    logic             clr_ovf;
    logic [WIDTH-1:0] rd_dat;

    assign sel      = tmr_reg_e'(addr[1:0]);
    assign wr_ctrl  = we && (sel == TMR_CTRL);
    assign wr_count = we && (sel == TMR_COUNT);
    assign wr_cmp   = we && (sel == TMR_CMP);
    assign wr_stat  = we && (sel == TMR_STAT);

    // Only the low byte lane carries the flags, so W1C needs be[0]
    assign clr_match = wr_stat && be[0] && wdata[STAT_MATCH];
    assign clr_ovf   = wr_stat && be[0] && wdata[STAT_OVF];

    // Register images as software sees them; reserved bits read as zero
    always_comb begin
        ctrl_img = '0;
        ctrl_img[CTRL_EN]     = ctrl_en;
        ctrl_img[CTRL_RELOAD] = ctrl_reload;
        ctrl_img[CTRL_IRQ_EN] = ctrl_irq_en;
        ctrl_img[CTRL_DIV_LSB +: PRESC_W] = ctrl_div;
        stat_img = '0;
        stat_img[STAT_MATCH] = match_f;
        stat_img[STAT_OVF]   = ovf_f;
    end

    assign ctrl_new = merge_bytes(ctrl_img, wdata, be);

    wire unused_bits = &{1'b0, addr[7:2],
                         ctrl_new[WIDTH-1:CTRL_DIV_LSB+PRESC_W],
                         ctrl_new[CTRL_DIV_LSB-1:CTRL_IRQ_EN+1]};

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_en),
        .clr  (wr_ctrl),
        .div  (ctrl_div),
        .tick (tick)
    );

    assign count_inc = count_r + WIDTH'(1);

    // Next count: software write beats the tick; match is judged on the incremented value
    always_comb begin
        count_nxt = count_r;
        set_match = 1'b0;
        set_ovf   = 1'b0;
        hw_stop   = 1'b0;
        if (wr_count) begin
            count_nxt = merge_bytes(count_r, wdata, be);
        end else if (tick) begin
            set_ovf = &count_r;
            if (count_inc == cmp_r) begin
                set_match = 1'b1;
                if (ctrl_reload) begin
                    count_nxt = '0;
                end else begin
                    count_nxt = count_inc;
                    hw_stop   = 1'b1;
                end
            end else begin
                count_nxt = count_inc;
            end
        end
    end

    // CTRL fields; a software write overrides the one-shot self-disable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_reload <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_div    <= '0;
        end else if (wr_ctrl) begin
            ctrl_en     <= ctrl_new[CTRL_EN];
            ctrl_reload <= ctrl_new[CTRL_RELOAD];
            ctrl_irq_en <= ctrl_new[CTRL_IRQ_EN];
            ctrl_div    <= ctrl_new[CTRL_DIV_LSB +: PRESC_W];
        end else if (hw_stop) begin
            ctrl_en <= 1'b0;
        end
    end

    // COUNT and COMPARE registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            cmp_r   <= '0;
        end else begin
            count_r <= count_nxt;
            if (wr_cmp) begin
                cmp_r <= merge_bytes(cmp_r, wdata, be);
            end
        end
    end

    // Sticky flags; a hardware set in the same cycle beats a W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_f <= 1'b0;
            ovf_f   <= 1'b0;
        end else begin
            match_f <= set_match | (match_f & ~clr_match);
            ovf_f   <= set_ovf   | (ovf_f   & ~clr_ovf);
        end
    end

    // Read mux on pre-write state, so read-during-write returns the old value
    always_comb begin
        rd_dat = '0;
        case (sel)
            TMR_CTRL:  rd_dat = ctrl_img;
            TMR_COUNT: rd_dat = count_r;
            TMR_CMP:   rd_dat = cmp_r;
            TMR_STAT:  rd_dat = stat_img;
            default:   rd_dat = '0;
        endcase
    end

    // Registered read data and level interrupt, both one cycle behind their sources
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            irq <= 1'b0;
        end else begin
            q   <= rd_dat;
            irq <= (match_f & ctrl_irq_en) | (ovf_f & ctrl_irq_en);
        end
    end

endmodule
